// File: rtl/modexp_ctrl.sv
// Modular exponentiation sequencer. Computes base^exponent mod modulus with a
// right-to-left square-and-multiply loop, driving one external modmult unit.
// R is the running product, B the running square, E the remaining exponent.
//
// Handshakes:
//   requester: start is taken only in IDLE (the cycle after done counts as
//   IDLE); busy covers every cycle from the one after accept up to but not
//   including the single done cycle; result/err are valid with done and
//   held until overwritten by the next job.
//   multiplier: mm_ds is raised for exactly one cycle, and only in a cycle
//   where mm_ready is high; the product is taken on the first edge where
//   mm_ready is high again after having been seen low.
module modexp_ctrl #(
    parameter int MPWID = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MPWID-1:0] base,
    input  logic [MPWID-1:0] exponent,
    input  logic [MPWID-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [MPWID-1:0] result,
    output logic             err,
    output logic [7:0]       mm_ops,
    output logic [MPWID-1:0] mm_mpand,
    output logic [MPWID-1:0] mm_mplier,
    output logic [MPWID-1:0] mm_modulus,
    output logic             mm_ds,
    input  logic             mm_ready,
    input  logic [MPWID-1:0] mm_product,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [MPWID-1:0] ONE = {{(MPWID-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [MPWID-1:0] r_r;
    logic [MPWID-1:0] r_b;
    logic [MPWID-1:0] r_e;
    logic [MPWID-1:0] r_mod;
    logic             r_op_sqr;
    logic [7:0]       r_ops;
    logic [MPWID-1:0] r_result;
    logic             r_err;
    logic             w_bad;
    logic             w_e_last;

    // B never reaches the modulus once the first check passes, so the
    // operand check is safe to repeat on every loop pass.
    assign w_bad    = (r_mod == '0) || (r_b >= r_mod);
    // After the current multiply no exponent bits remain: skip the square.
    assign w_e_last = (r_e[MPWID-1:1] == '0);

    assign result     = r_result;
    assign err        = r_err;
    assign mm_ops     = r_ops;
    assign mm_mpand   = r_op_sqr ? r_b : r_r;
    assign mm_mplier  = r_b;
    assign mm_modulus = r_mod;
    assign dbg_state  = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision for the loop and the per-operation handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_bad || (r_e == '0)) w_next = S_DONE;
                else                      w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (mm_ready) w_next = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!mm_ready) w_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (mm_ready) begin
                    if (r_op_sqr)      w_next = S_CHECK;
                    else if (w_e_last) w_next = S_DONE;
                    else               w_next = S_ISSUE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Requester and multiplier strobes decoded from the current state.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        mm_ds = 1'b0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_DONE:  done = 1'b1;
            S_ISSUE: begin
                busy  = 1'b1;
                mm_ds = mm_ready;
            end
            default: busy = 1'b1;
        endcase
    end

    // Operand latching, loop registers, op counter and result capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_r      <= '0;
            r_b      <= '0;
            r_e      <= '0;
            r_mod    <= '0;
            r_op_sqr <= 1'b0;
            r_ops    <= 8'd0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_b   <= base;
                        r_e   <= exponent;
                        r_mod <= modulus;
                        r_r   <= (modulus == ONE) ? '0 : ONE;
                        r_ops <= 8'd0;
                        r_err <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end else if (r_e == '0) begin
                        r_result <= r_r;
                    end else begin
                        r_op_sqr <= ~r_e[0];
                    end
                end
                S_ISSUE: begin
                    if (mm_ready && (r_ops != 8'hFF)) r_ops <= r_ops + 8'd1;
                end
                S_WAIT_HI: begin
                    if (mm_ready) begin
                        if (r_op_sqr) begin
                            r_b <= mm_product;
                            r_e <= r_e >> 1;
                        end else begin
                            r_r <= mm_product;
                            if (w_e_last) r_result <= mm_product;
                            else          r_op_sqr <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencer that computes result = base^exponent mod modulus by driving one external modmult instance through a right-to-left square-and-multiply loop.
- Sits between a requester (start/done handshake) and the modular multiplier datapath. Owns the multiplier's operand, modulus and ds lines while busy.
- Holds the running product R and the running square B in internal MPWID-bit registers.

Parameters:
- MPWID, 32, operand/modulus/result width; must equal the attached modmult MPWID.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- base  in  MPWID  base operand; sampled on accepted start.
- exponent  in  MPWID  exponent; sampled on accepted start.
- modulus  in  MPWID  modulus; sampled on accepted start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when result/err are valid.
- result  out  MPWID  final value; held until the next accepted start.
- err  out  1  operand error; valid with done, held with result.
- mm_ops  out  8  count of multiplier operations issued for the current job; saturates at 255.
- mm_mpand  out  MPWID  multiplier multiplicand.
- mm_mplier  out  MPWID  multiplier multiplier operand.
- mm_modulus  out  MPWID  multiplier modulus; equals the latched modulus.
- mm_ds  out  1  multiplier data strobe; at most one cycle per operation.
- mm_ready  in  1  multiplier ready; high when idle or finished.
- mm_product  in  MPWID  multiplier result; valid while mm_ready is high after completion.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE. busy=0, done=0, err=0, result=0, mm_ds=0, mm_ops=0, R=B=E=0, mm operand outputs=0.
- Reset mid-job aborts immediately with no done pulse. The multiplier may still be mid-operation; the controller must not issue mm_ds until it has observed mm_ready==1.
- Accept: start==1 in IDLE latches base, exponent and modulus, clears mm_ops and err, and sets busy next cycle.
- Operand checks, evaluated in the CHECK state:
  - modulus==0 or base>=modulus: err=1, result=0, go to DONE without issuing any operation.
  - Otherwise: R = (modulus==1) ? 0 : 1, B = base, E = exponent.
- Loop states:
  - CHECK -> if E==0, DONE; else if E[0], MUL; else SQR.
  - MUL: operation R <= R*B mod m (mpand=R, mplier=B). Then, if (E>>1)==0, DONE; else SQR.
  - SQR: operation B <= B*B mod m (mpand=B, mplier=B). Then E <= E>>1 and return to CHECK.
  - The final square is always skipped.
- Per-operation sub-sequence:
  - ISSUE: hold operands stable. In the first cycle with mm_ready==1, assert mm_ds for exactly one cycle and increment mm_ops.
  - WAIT_LO: wait for mm_ready==0.
  - WAIT_HI: wait for mm_ready==1, then capture mm_product into R or B on that edge.
  - Operands remain stable from ISSUE through WAIT_HI.
  - A mplier of 0 is legal: mm_ready drops for one cycle and the product is 0.
- DONE: for one cycle result<=R (or 0 on err), done=1, busy=0, then return to IDLE.
- start while busy is ignored. start in the DONE cycle is ignored. start in the cycle after done is accepted.
- Width rules:
  - All registers are MPWID bits.
  - mm_ops saturates at 255.
  - The multiplier precondition (operands < modulus) is guaranteed by the base check plus closure of mod arithmetic.
- Operation count: popcount(exponent) + (bit index of MSB of exponent). Exponent 0 gives 0 operations.

Test Plan:
- base=4, exponent=13, modulus=497 -> result=445, err=0, mm_ops=6, exactly one done pulse, busy high throughout.
- base=5, exponent=3, modulus=7 -> result=6, mm_ops=3. Each mm_ds pulse is exactly one cycle and occurs only while mm_ready==1.
- base=3, exponent=0, modulus=7 -> result=1, mm_ops=0, done within 3 cycles of accept. Same job with modulus=1, base=0 -> result=0.
- base=10, modulus=7 (base>=modulus), and separately modulus=0 -> err=1, result=0, mm_ops=0, mm_ds never asserted.
- Drive reset=0 during WAIT_LO of the second operation, then release -> outputs at reset values, no done pulse. A new job (base=2, exponent=10, modulus=1000) -> result=24 and first mm_ds is waited out until mm_ready==1.
- Pulse start repeatedly during a busy job -> ignored, latched operands unchanged, single done. Back-to-back jobs with start held high -> second job accepted the cycle after done.
